// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory arbiter slice.
//   clog2_min1  : ceil(log2(n)) but never below 1, for ID/pointer widths
//   req_bits_t  : request payload at the default AW/DW widths
//   DEF_*       : default parameter values used by the interface and top
package mem_arb_pkg;

  localparam int DEF_N_REQ           = 2;
  localparam int DEF_AW              = 32;
  localparam int DEF_DW              = 32;
  localparam int DEF_BW              = DEF_DW / 8;
  localparam int DEF_MAX_OUTSTANDING = 4;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] data;
    logic [DEF_BW-1:0] be;
    logic              is_write;
  } req_bits_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and target-side memory req/rsp bundle.
//   Requester side : io_req_* (valid/ready, packed per-requester bits),
//                    io_rsp_valid (one-hot), io_rsp_bits_dataResponse
//   Target side    : io_mem_req_* (valid/ready + bits), io_mem_rsp_*
// Modports:
//   slave  - the arbiter's view (accepts requester traffic, drives target)
//   master - the environment's view (requesters + memory target)
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
);
  localparam int BW = DW / 8;

  logic [N_REQ-1:0]    io_req_valid;
  logic [N_REQ-1:0]    io_req_ready;
  logic [N_REQ*AW-1:0] io_req_bits_addrRequest;
  logic [N_REQ*DW-1:0] io_req_bits_dataRequest;
  logic [N_REQ*BW-1:0] io_req_bits_activeByteLane;
  logic [N_REQ-1:0]    io_req_bits_isWrite;
  logic [N_REQ-1:0]    io_rsp_valid;
  logic [DW-1:0]       io_rsp_bits_dataResponse;

  logic                io_mem_req_valid;
  logic                io_mem_req_ready;
  logic [AW-1:0]       io_mem_req_bits_addrRequest;
  logic [DW-1:0]       io_mem_req_bits_dataRequest;
  logic [BW-1:0]       io_mem_req_bits_activeByteLane;
  logic                io_mem_req_bits_isWrite;
  logic                io_mem_rsp_valid;
  logic [DW-1:0]       io_mem_rsp_bits_dataResponse;

  modport slave (
    input  io_req_valid, io_req_bits_addrRequest, io_req_bits_dataRequest,
           io_req_bits_activeByteLane, io_req_bits_isWrite,
           io_mem_req_ready, io_mem_rsp_valid, io_mem_rsp_bits_dataResponse,
    output io_req_ready, io_rsp_valid, io_rsp_bits_dataResponse,
           io_mem_req_valid, io_mem_req_bits_addrRequest,
           io_mem_req_bits_dataRequest, io_mem_req_bits_activeByteLane,
           io_mem_req_bits_isWrite
  );

  modport master (
    output io_req_valid, io_req_bits_addrRequest, io_req_bits_dataRequest,
           io_req_bits_activeByteLane, io_req_bits_isWrite,
           io_mem_req_ready, io_mem_rsp_valid, io_mem_rsp_bits_dataResponse,
    input  io_req_ready, io_rsp_valid, io_rsp_bits_dataResponse,
           io_mem_req_valid, io_mem_req_bits_addrRequest,
           io_mem_req_bits_dataRequest, io_mem_req_bits_activeByteLane,
           io_mem_req_bits_isWrite
  );

endinterface

// File: rtl/mem_arb_id_fifo.sv
// mem_arb_id_fifo: small synchronous FIFO of requester IDs.
//   clock, reset : clock, synchronous active-high reset (flushes)
//   push, din    : enqueue din (ignored when full unless popping)
//   pop          : dequeue head (ignored when empty)
//   head         : current head entry
//   full, empty  : occupancy flags
// Push and pop in the same cycle both take effect at any occupancy,
// including full, leaving the count unchanged.
module mem_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_eff, pop_eff;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_eff) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_eff) wr_ptr <= nxt(wr_ptr);
      if (pop_eff)  rd_ptr <= nxt(rd_ptr);
      unique case ({push_eff, pop_eff})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N_REQ-requester to single-target memory arbiter.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : requester req/rsp and target req/rsp signals
// Grant is combinational: round-robin from ptr (or fixed priority, lowest
// index first, when MEM_ARB_FIXED_PRIO_EN is defined). A request the target
// stalls locks the grant so target-side valid/bits hold until accepted.
// Each accepted request's requester ID goes into an in-order FIFO; each
// target response pops the head and is routed one-hot to that requester.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ           = DEF_N_REQ,
  parameter int AW              = DEF_AW,
  parameter int DW              = DEF_DW,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int BW = DW / 8;
  localparam int IW = clog2_min1(N_REQ);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic          is_write;
  } lane_bits_t;

  lane_bits_t [N_REQ-1:0] lane;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign lane[gi].addr     = bus.io_req_bits_addrRequest[gi*AW +: AW];
    assign lane[gi].data     = bus.io_req_bits_dataRequest[gi*DW +: DW];
    assign lane[gi].be       = bus.io_req_bits_activeByteLane[gi*BW +: BW];
    assign lane[gi].is_write = bus.io_req_bits_isWrite[gi];
  end

  logic             lock;
  logic [IW-1:0]    lock_id;
  logic [IW-1:0]    gnt;
  logic             gnt_vld;
  logic             can_issue;
  logic             mem_valid;
  logic             mem_hs;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ-1:0] rsp_vld;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [IW-1:0]    fifo_head;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [IW-1:0]    ptr;
  int               scan_idx;
`endif

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign fifo_pop  = bus.io_mem_rsp_valid && !fifo_empty;
  assign can_issue = !fifo_full || fifo_pop;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
    scan_idx = 0;
`endif
    if (lock) begin
      gnt     = lock_id;
      gnt_vld = bus.io_req_valid[lock_id];
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (!gnt_vld && bus.io_req_valid[k]) begin
          gnt     = k[IW-1:0];
          gnt_vld = 1'b1;
        end
`else
        scan_idx = int'(ptr) + k;
        if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
        if (!gnt_vld && bus.io_req_valid[scan_idx]) begin
          gnt     = scan_idx[IW-1:0];
          gnt_vld = 1'b1;
        end
`endif
      end
    end
  end

  assign mem_valid = !reset && gnt_vld && can_issue;
  assign mem_hs    = mem_valid && bus.io_mem_req_ready;

  always_comb begin
    req_ready = '0;
    if (mem_valid) req_ready[gnt] = bus.io_mem_req_ready;
  end

  always_comb begin
    rsp_vld = '0;
    if (!reset && fifo_pop) rsp_vld[fifo_head] = 1'b1;
  end

  assign bus.io_req_ready                   = req_ready;
  assign bus.io_rsp_valid                   = rsp_vld;
  assign bus.io_rsp_bits_dataResponse       = bus.io_mem_rsp_bits_dataResponse;
  assign bus.io_mem_req_valid               = mem_valid;
  assign bus.io_mem_req_bits_addrRequest    = lane[gnt].addr;
  assign bus.io_mem_req_bits_dataRequest    = lane[gnt].data;
  assign bus.io_mem_req_bits_activeByteLane = lane[gnt].be;
  assign bus.io_mem_req_bits_isWrite        = lane[gnt].is_write;

  // Lock holds the grant across target stalls; cleared by the handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock    <= 1'b0;
      lock_id <= '0;
    end else if (mem_hs) begin
      lock    <= 1'b0;
    end else if (mem_valid) begin
      lock    <= 1'b1;
      lock_id <= gnt;
    end
  end

`ifndef MEM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clock) begin
    if (reset)       ptr <= '0;
    else if (mem_hs) ptr <= (gnt == IW'(N_REQ - 1)) ? '0 : gnt + IW'(1);
  end
`endif

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IW)
  ) u_id_fifo (
    .clock (clock),
    .reset (reset),
    .push  (mem_hs),
    .din   (gnt),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Protocol checks: locked requester must keep valid high, and the target
  // must never answer with nothing outstanding.
  always_ff @(posedge clock) begin
    if (!reset && lock)                 assert (bus.io_req_valid[lock_id]);
    if (!reset && bus.io_mem_rsp_valid) assert (!fifo_empty);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-requester to 1-target arbiter on the core memory req/rsp interface (valid/ready request; valid-only response).
- Lets imem, dmem and future masters (debug, DMA) share one SRamTop-class memory.
- Sits between Core-level initiators and a single memory instance in the next-generation core top.
- Round-robin grant; in-order response routing through an outstanding-ID FIFO.

Parameters:
- N_REQ, 2, number of requesters (>=2)
- AW, 32, address width
- DW, 32, data width (multiple of 8); byte-lane width BW = DW/8
- MAX_OUTSTANDING, 4, accepted-but-unanswered requests tracked (power of 2, >=1)

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- io_req_valid  in  N_REQ  per-requester request valid
- io_req_ready  out  N_REQ  per-requester accept
- io_req_bits_addrRequest  in  N_REQ*AW  packed addresses; requester i at [i*AW +: AW]
- io_req_bits_dataRequest  in  N_REQ*DW  packed write data
- io_req_bits_activeByteLane  in  N_REQ*BW  packed byte enables
- io_req_bits_isWrite  in  N_REQ  write flag
- io_rsp_valid  out  N_REQ  one-hot response valid
- io_rsp_bits_dataResponse  out  DW  response data, broadcast to all requesters
- io_mem_req_valid  out  1  target request valid
- io_mem_req_ready  in  1  target accept
- io_mem_req_bits_addrRequest  out  AW  granted address
- io_mem_req_bits_dataRequest  out  DW  granted write data
- io_mem_req_bits_activeByteLane  out  BW  granted byte enables
- io_mem_req_bits_isWrite  out  1  granted write flag
- io_mem_rsp_valid  in  1  target response valid
- io_mem_rsp_bits_dataResponse  in  DW  target response data

Behaviour:
- Single clock domain. reset is synchronous and active-high. While reset is high: all io_req_ready, io_mem_req_valid and io_rsp_valid are 0; the RR pointer is 0; the FIFO is empty; the lock is clear.
- Target contract: exactly one response per accepted request (reads and writes alike), returned in acceptance order, at least 1 cycle after acceptance.
- can_issue = !fifo_full || pop_this_cycle. Full with a simultaneous pop still accepts.
- Arbitration (combinational, zero latency):
  - Among valid requesters, grant the first at or after ptr (modulo N_REQ).
  - io_mem_req_valid = any valid && can_issue. The mem bits mux the granted requester.
  - io_req_ready[g] = io_mem_req_ready && can_issue; all other bits of io_req_ready are 0.
- Lock: if io_mem_req_valid && !io_mem_req_ready, register lock = 1 and lock_id = g. While locked, the grant is forced to lock_id, so target-side valid/bits stay stable. Lock clears on handshake.
  - Requesters must hold valid until ready. Lock behaviour if a requester drops valid is undefined and is flagged by an assertion.
- On handshake: push g into the FIFO; ptr <= (g+1) mod N_REQ.
- Response: when io_mem_rsp_valid is high, pop the FIFO head h.
  - io_rsp_valid = onehot(h), same cycle, zero latency.
  - Data passes through.
- io_mem_rsp_valid with an empty FIFO: response dropped, no io_rsp_valid, assertion fires.
- FIFO: MAX_OUTSTANDING entries, ID width max(1,$clog2(N_REQ)). Pointers wrap naturally. Count width is $clog2(MAX_OUTSTANDING)+1.
- Simultaneous push and pop at any occupancy: count unchanged, both operations take effect.
- Reset mid-operation: FIFO flushed and lock cleared. The target shares the same reset, so no stale responses are expected.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins (requester 0 = dmem highest). ptr is not used and not updated. Lock and FIFO behaviour are unchanged.
- Undefined: round-robin as described above.

Decomposition:
- Package mem_arb_pkg holds: function clog2_min1, typedef req_bits_t (addr/data/be/isWrite, sized by AW/DW), localparam-style default widths.
- One sub-module, mem_arb_id_fifo: parametrised sync FIFO with push, pop, full, empty, head and same-cycle push/pop support.
- Arbiter core (RR pointer, lock, muxing) stays in mem_arbiter.

Test Plan:
- N_REQ=2, target always ready, fixed 1-cycle response; both valid continuously.
  -> Grants alternate 0,1,0,1. io_rsp_valid alternates 01,10 one cycle later.
- Req0 read addr 0x100 while target ready=0 for 3 cycles, req1 asserted in cycle 2.
  -> Mem bits stay at 0x100 until handshake. Req1 is granted next.
- MAX_OUTSTANDING=4, target holds responses. Six back-to-back requests.
  -> 4 accepted, then io_req_ready=0. The first response allows accept in the same cycle (push+pop).
- Requester 1 write data 0xDEADBEEF, be 4'b0011, addr 0x20.
  -> Mem port shows the exact bits. The write response returns io_rsp_valid=2'b10.
- Reset asserted with 3 requests outstanding.
  -> Next cycle FIFO empty, ptr=0, all outputs 0. The first post-reset grant goes to requester 0.
- With MEM_ARB_FIXED_PRIO_EN defined and both valid.
  -> Requester 0 granted every cycle and requester 1 starves until req0 valid drops.
